// File: rtl/cnt_pair_checker_pkg.sv
// Shared types and constants for the x/y counter-pair stream checker.
package cnt_pair_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Bit positions inside err_code
  localparam int unsigned ERR_X_MIS     = 0;
  localparam int unsigned ERR_Y_MIS     = 1;
  localparam int unsigned ERR_Y_NOT_CLR = 2;
  localparam int unsigned ERR_CODE_W    = 3;

  // Bits needed to hold values 0..max_val
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cnt_pair_checker_if.sv
// Sample/result bundle between the stream source and the checker.
interface cnt_pair_checker_if
  import cnt_pair_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned ERR_CNT_W = 8
);

  logic                  in_valid;
  logic [W-1:0]          x_in;
  logic [W-1:0]          y_in;
  logic                  resync;
  logic                  locked;
  logic                  err_pulse;
  logic [ERR_CODE_W-1:0] err_code;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [W-1:0]          exp_x;
  logic [W-1:0]          exp_y;

  modport master (
    output in_valid, x_in, y_in, resync,
    input  locked, err_pulse, err_code, err_count, exp_x, exp_y
  );

  modport slave (
    input  in_valid, x_in, y_in, resync,
    output locked, err_pulse, err_code, err_count, exp_x, exp_y
  );

endinterface

// File: rtl/cnt_pair_checker_model.sv
// Combinational predictor: next (x, y, hold_cnt) from the current model pair.
module cnt_pair_model
  import cnt_pair_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned Y_CLR_LIM = 3,
  parameter int unsigned X_HOLD    = 3,
  parameter int unsigned HOLD_LEN  = 4,
  parameter int unsigned HC_W      = cnt_w(HOLD_LEN)
) (
  input  logic [W-1:0]    x_i,
  input  logic [W-1:0]    y_i,
  input  logic [HC_W-1:0] hold_i,
  output logic [W-1:0]    x_nxt_c,
  output logic [W-1:0]    y_nxt_c,
  output logic [HC_W-1:0] hold_nxt_c
);

  // x sticks at X_HOLD for HOLD_LEN samples; hold counts repeats after entry
  always_comb begin
    x_nxt_c    = x_i + W'(1);
    hold_nxt_c = '0;
    if (x_i == W'(X_HOLD) && hold_i < HC_W'(HOLD_LEN - 1)) begin
      x_nxt_c = x_i;
    end
    if (x_nxt_c == W'(X_HOLD) && x_i == W'(X_HOLD)) begin
      hold_nxt_c = hold_i + HC_W'(1);
    end
    y_nxt_c = (x_nxt_c < W'(Y_CLR_LIM)) ? '0 : (y_i + W'(1));
  end

endmodule

// File: rtl/cnt_pair_checker.sv
// Locks onto the x/y counter-pair stream and flags samples that break the override rules.
module cnt_pair_checker
  import cnt_pair_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned Y_CLR_LIM = 3,
  parameter int unsigned X_HOLD    = 3,
  parameter int unsigned HOLD_LEN  = 4,
  parameter int unsigned MISS_LIM  = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic               clk,
  input logic               reset,
  cnt_pair_checker_if.slave bus
);

  localparam int unsigned HC_W   = cnt_w(HOLD_LEN);
  localparam int unsigned MISS_W = cnt_w(MISS_LIM);

  // Only the prediction for the next sample is stored; the model pair is implicit.
  state_e                state_q, state_d;
  logic                  loaded_q, loaded_d;
  logic [W-1:0]          pred_x_q, pred_x_d;
  logic [W-1:0]          pred_y_q, pred_y_d;
  logic [HC_W-1:0]       pred_h_q, pred_h_d;
  logic [MISS_W-1:0]     miss_q, miss_d;
  logic                  locked_q, locked_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [ERR_CODE_W-1:0] err_code_q, err_code_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  logic                  mismatch_c;
  logic                  miss_hit_c;
  logic                  at_hold_c;
  logic                  use_sample_c;
  logic [ERR_CODE_W-1:0] code_c;
  logic [W-1:0]          m_x, m_y, n_x, n_y;
  logic [HC_W-1:0]       m_h, n_h;

  // Compare the sample against the prediction and decide what the model advances from
  always_comb begin
    code_c                = '0;
    code_c[ERR_X_MIS]     = (bus.x_in != pred_x_q);
    code_c[ERR_Y_MIS]     = (bus.y_in != pred_y_q) && (pred_y_q != '0);
    code_c[ERR_Y_NOT_CLR] = (bus.y_in != pred_y_q) && (pred_y_q == '0);
    mismatch_c            = (code_c != '0);
    miss_hit_c            = (miss_q + MISS_W'(1)) >= MISS_W'(MISS_LIM);
    at_hold_c             = (pred_x_q == W'(X_HOLD));
    case (state_q)
      IDLE:        use_sample_c = 1'b1;
      SYNC:        use_sample_c = !loaded_q || mismatch_c;
      TRACK, HOLD: use_sample_c = mismatch_c && miss_hit_c;
      default:     use_sample_c = 1'b1;
    endcase
  end

  assign m_x = use_sample_c ? bus.x_in : pred_x_q;
  assign m_y = use_sample_c ? bus.y_in : pred_y_q;
  assign m_h = use_sample_c ? '0 : pred_h_q;

  cnt_pair_model #(
    .W         (W),
    .Y_CLR_LIM (Y_CLR_LIM),
    .X_HOLD    (X_HOLD),
    .HOLD_LEN  (HOLD_LEN),
    .HC_W      (HC_W)
  ) u_model (
    .x_i        (m_x),
    .y_i        (m_y),
    .hold_i     (m_h),
    .x_nxt_c    (n_x),
    .y_nxt_c    (n_y),
    .hold_nxt_c (n_h)
  );

  // Lock FSM, miss/error counters and prediction update
  always_comb begin
    state_d     = state_q;
    loaded_d    = loaded_q;
    pred_x_d    = pred_x_q;
    pred_y_d    = pred_y_q;
    pred_h_d    = pred_h_q;
    miss_d      = miss_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    err_code_d  = '0;
    if (bus.resync) begin
      state_d  = SYNC;
      loaded_d = 1'b0;
      pred_x_d = '0;
      pred_y_d = '0;
      pred_h_d = '0;
      miss_d   = '0;
    end else if (bus.in_valid) begin
      pred_x_d = n_x;
      pred_y_d = n_y;
      pred_h_d = n_h;
      case (state_q)
        IDLE: begin
          state_d  = SYNC;
          loaded_d = 1'b1;
        end
        SYNC: begin
          loaded_d = 1'b1;
          if (loaded_q && !mismatch_c) begin
            state_d = at_hold_c ? HOLD : TRACK;
          end
        end
        TRACK, HOLD: begin
          if (mismatch_c) begin
            err_pulse_d = 1'b1;
            err_code_d  = code_c;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_CNT_W'(1);
            end
            if (miss_hit_c) begin
              state_d = SYNC;
              miss_d  = '0;
            end else begin
              state_d = at_hold_c ? HOLD : TRACK;
              miss_d  = miss_q + MISS_W'(1);
            end
          end else begin
            state_d = at_hold_c ? HOLD : TRACK;
            miss_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    locked_d = (state_d == TRACK) || (state_d == HOLD);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      loaded_q    <= 1'b0;
      pred_x_q    <= '0;
      pred_y_q    <= '0;
      pred_h_q    <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      loaded_q    <= loaded_d;
      pred_x_q    <= pred_x_d;
      pred_y_q    <= pred_y_d;
      pred_h_q    <= pred_h_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_count = err_count_q;
  assign bus.exp_x     = pred_x_q;
  assign bus.exp_y     = pred_y_q;

endmodule

// File: tb/tb_cnt_pair_checker.sv
// Directed bench for cnt_pair_checker: vector table plus hand-written lock/saturation/reset sequences.
module tb_cnt_pair_checker;
  import cnt_pair_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnt_pair_checker_if #(.W(4), .ERR_CNT_W(8)) bus_a ();
  cnt_pair_checker_if #(.W(4), .ERR_CNT_W(8)) bus_b ();

  cnt_pair_checker dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  cnt_pair_checker #(.MISS_LIM(1000)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  typedef struct {
    logic       iv;
    logic [3:0] x;
    logic [3:0] y;
    logic       rs;
    logic       lk;
    logic       pl;
    logic [2:0] cd;
    logic [7:0] cnt;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[19];
  logic [3:0] sx[320];
  logic [3:0] sy[320];

  function automatic vec_t mk(input int iv, input int x, input int y, input int rs,
                              input int lk, input int pl, input int cd, input int cnt);
    vec_t v;
    v.iv  = 1'(iv);
    v.x   = 4'(x);
    v.y   = 4'(y);
    v.rs  = 1'(rs);
    v.lk  = 1'(lk);
    v.pl  = 1'(pl);
    v.cd  = 3'(cd);
    v.cnt = 8'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle on DUT a (sel=0) or DUT b (sel=1); sample #1 after the edge
  task automatic drive(input bit sel, input logic iv, input logic [3:0] x, input logic [3:0] y,
                       input logic rs);
    if (!sel) begin
      bus_a.in_valid = iv; bus_a.x_in = x; bus_a.y_in = y; bus_a.resync = rs;
    end else begin
      bus_b.in_valid = iv; bus_b.x_in = x; bus_b.y_in = y; bus_b.resync = rs;
    end
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0; bus_a.resync = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.resync = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, ".locked"},    32'(bus_a.locked),    0);
    chk({tag, ".err_pulse"}, 32'(bus_a.err_pulse), 0);
    chk({tag, ".err_code"},  32'(bus_a.err_code),  0);
    chk({tag, ".err_count"}, 32'(bus_a.err_count), 0);
    chk({tag, ".exp_x"},     32'(bus_a.exp_x),     0);
    chk({tag, ".exp_y"},     32'(bus_a.exp_y),     0);
  endtask

  initial begin
    // Reference stream: x counts up, sitting on 3 for four samples; y cleared while x<3
    begin
      int xv, yv, rep;
      xv = 0; yv = 0; rep = 0;
      for (int i = 0; i < 320; i++) begin
        sx[i] = 4'(xv);
        sy[i] = 4'(yv);
        if (xv == 3 && rep < 3) rep++;
        else begin
          xv  = (xv + 1) % 16;
          rep = 0;
        end
        yv = (xv < 3) ? 0 : (yv + 1) % 16;
      end
    end

    //          iv  x   y rs lk pl   cd   cnt
    tbl[0]  = mk(1, 14, 12, 0, 0, 0, 3'b000, 0);
    tbl[1]  = mk(1, 15, 13, 0, 1, 0, 3'b000, 0);
    tbl[2]  = mk(1,  0,  0, 0, 1, 0, 3'b000, 0);
    tbl[3]  = mk(1,  1,  5, 0, 1, 1, 3'b100, 1);
    tbl[4]  = mk(0,  0,  0, 0, 1, 0, 3'b000, 1);
    tbl[5]  = mk(1,  2,  0, 0, 1, 0, 3'b000, 1);
    tbl[6]  = mk(1,  3,  1, 0, 1, 0, 3'b000, 1);
    tbl[7]  = mk(1,  9,  2, 0, 1, 1, 3'b001, 2);
    tbl[8]  = mk(1,  9,  3, 0, 1, 1, 3'b001, 3);
    tbl[9]  = mk(1,  9,  4, 0, 0, 1, 3'b001, 4);
    tbl[10] = mk(1, 10,  5, 0, 1, 0, 3'b000, 4);
    tbl[11] = mk(1, 11,  6, 0, 1, 0, 3'b000, 4);
    tbl[12] = mk(1,  0,  0, 1, 0, 0, 3'b000, 4);
    tbl[13] = mk(0,  0,  0, 0, 0, 0, 3'b000, 4);
    tbl[14] = mk(1,  7,  7, 0, 0, 0, 3'b000, 4);
    tbl[15] = mk(1,  8,  8, 0, 1, 0, 3'b000, 4);
    tbl[16] = mk(1,  9,  9, 0, 1, 0, 3'b000, 4);
    tbl[17] = mk(1, 11,  3, 0, 1, 1, 3'b011, 5);
    tbl[18] = mk(1, 11, 11, 0, 1, 0, 3'b000, 5);

    bus_a.in_valid = 1'b0; bus_a.x_in = '0; bus_a.y_in = '0; bus_a.resync = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.x_in = '0; bus_b.y_in = '0; bus_b.resync = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_a("reset");
    reset = 1'b0;

    // Clean stream from (0,0) through the x wrap
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, sx[i], sy[i], 1'b0);
      chk($sformatf("stream%0d.locked", i), 32'(bus_a.locked), 32'(i >= 1));
      chk($sformatf("stream%0d.err_pulse", i), 32'(bus_a.err_pulse), 0);
      chk($sformatf("stream%0d.exp_x", i), 32'(bus_a.exp_x), 32'(sx[i+1]));
      chk($sformatf("stream%0d.exp_y", i), 32'(bus_a.exp_y), 32'(sy[i+1]));
    end
    chk("stream.err_count", 32'(bus_a.err_count), 0);

    // Vector table: y-not-clear, lock loss, resync, combined x/y error
    pulse_reset();
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, tbl[i].iv, tbl[i].x, tbl[i].y, tbl[i].rs);
      chk($sformatf("vec%0d.locked", i),    32'(bus_a.locked),    32'(tbl[i].lk));
      chk($sformatf("vec%0d.err_pulse", i), 32'(bus_a.err_pulse), 32'(tbl[i].pl));
      chk($sformatf("vec%0d.err_code", i),  32'(bus_a.err_code),  32'(tbl[i].cd));
      chk($sformatf("vec%0d.err_count", i), 32'(bus_a.err_count), 32'(tbl[i].cnt));
    end

    // Saturation on a checker that never drops lock
    pulse_reset();
    drive(1'b1, 1'b1, sx[0], sy[0], 1'b0);
    drive(1'b1, 1'b1, sx[1], sy[1], 1'b0);
    chk("sat.locked_start", 32'(bus_b.locked), 1);
    for (int k = 1; k <= 300; k++) begin
      drive(1'b1, 1'b1, sx[k+1], sy[k+1] ^ 4'd1, 1'b0);
      chk($sformatf("sat%0d.err_pulse", k), 32'(bus_b.err_pulse), 1);
      chk($sformatf("sat%0d.err_count", k), 32'(bus_b.err_count), (k > 255) ? 255 : k);
    end
    chk("sat.locked_end", 32'(bus_b.locked), 1);

    // Reset while holding x at 3 with hold_cnt=2, then relock
    pulse_reset();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, sx[i], sy[i], 1'b0);
    drive(1'b0, 1'b1, sx[5], sy[5] ^ 4'd1, 1'b0);
    chk("hold.err_pulse", 32'(bus_a.err_pulse), 1);
    chk("hold.err_count", 32'(bus_a.err_count), 1);
    chk("hold.exp_x",     32'(bus_a.exp_x),     3);
    reset = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.x_in = 4'd3; bus_a.y_in = 4'd4;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_a.in_valid = 1'b0;
    chk_zero_a("hold_reset");
    drive(1'b0, 1'b1, 4'd5, 4'd5, 1'b0);
    chk("relock1.locked", 32'(bus_a.locked), 0);
    chk("relock1.exp_x",  32'(bus_a.exp_x),  6);
    drive(1'b0, 1'b1, 4'd6, 4'd6, 1'b0);
    chk("relock2.locked",    32'(bus_a.locked),    1);
    chk("relock2.exp_x",     32'(bus_a.exp_x),     7);
    chk("relock2.exp_y",     32'(bus_a.exp_y),     7);
    chk("relock2.err_count", 32'(bus_a.err_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
